mcycle_seq: RTL and testbench

Parametrised multicycle control sequencer for the 16-bit TSC CPU. It drives the datapath enables and mux selects state by state, and tolerates variable memory latency through a `mem_ready` handshake instead of assuming a fixed-cycle memory. It also owns the retired-instruction counter, the WWD output strobe and halt. It sits between the instruction register/ALU flags and the datapath (PC, register file, memory bus).

---
 rtl/mcycle_seq.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_mcycle_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcycle_seq.sv
// mcycle_seq: multicycle control sequencer for the 16-bit TSC CPU.
//
// Steps each instruction through IF/ID/EX/MEM/WB. It drives the datapath
// enables and mux selects, waits on a mem_ready handshake for variable
// memory latency, counts retired instructions and handles WWD/HLT.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   inst              IR contents (opcode = inst[15:12], func = inst[5:0])
//   bcond             ALU branch condition, valid in EX
//   mem_ready         memory completed the pending request this cycle
//   mem_read/write    memory request, held until mem_ready
//   addr_sel          address bus source: 0 = PC, 1 = ALU result
//   ir_write          latch read data into IR
//   mdr_write         latch read data into MDR
//   pc_write, pc_src  PC update; 0 = PC+1, 1 = jump, 2 = branch, 3 = reg A
//   reg_write         register-file write enable
//   wb_reg_sel        0 = rt, 1 = rd, 2 = $2
//   wb_data_sel       0 = ALU, 1 = MDR, 2 = PC
//   alu_src_imm       ALU operand 2 is the immediate
//   out_valid         one-cycle WWD strobe
//   is_halted         HLT executed
//   mem_err           memory wait timed out (sticky until reset)
//   num_inst          retired-instruction count, wraps
//
// Build option: define MCYCLE_SEQ_TIMEOUT_EN to enable the memory wait
// timeout (TIMEOUT cycles with mem_ready low in IF/MEM -> ERR state).
// Without it IF/MEM wait indefinitely and mem_err is tied 0.

module mcycle_seq #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      inst,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_reg_sel,
  output logic [1:0]       wb_data_sel,
  output logic             alu_src_imm,
  output logic             out_valid,
  output logic             is_halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] num_inst
);

  typedef enum logic [2:0] {
    StRst, StIf, StId, StEx, StMem, StWb, StHalt, StErr
  } state_e;

  // Instruction classes; everything the sequencer needs from the IR.
  typedef enum logic [3:0] {
    ClsNop, ClsJmp, ClsJal, ClsHlt, ClsAlu, ClsImm,
    ClsLwd, ClsSwd, ClsBr, ClsJpr, ClsJrl, ClsWwd
  } cls_e;

  localparam logic [1:0] PcSeq  = 2'd0;
  localparam logic [1:0] PcJmp  = 2'd1;
  localparam logic [1:0] PcBr   = 2'd2;
  localparam logic [1:0] PcRegA = 2'd3;

  localparam logic [1:0] RegRt = 2'd0;
  localparam logic [1:0] RegRd = 2'd1;
  localparam logic [1:0] RegR2 = 2'd2;

  localparam logic [1:0] DataAlu = 2'd0;
  localparam logic [1:0] DataMdr = 2'd1;
  localparam logic [1:0] DataPc  = 2'd2;

  state_e           state_q, state_d;
  cls_e             cls;
  logic [CNT_W-1:0] num_q, num_d;
  logic             retire;

  logic [3:0] opcode;
  logic [5:0] func;
  assign opcode = inst[15:12];
  assign func   = inst[5:0];

  // Register fields are routed by the datapath, not decoded here.
  logic unused_inst;
  assign unused_inst = ^inst[11:6];

  // ---------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------
  always_comb begin
    cls = ClsNop;
    case (opcode)
      4'd0, 4'd1, 4'd2, 4'd3: cls = ClsBr;
      4'd4, 4'd5, 4'd6:       cls = ClsImm;
      4'd7:                   cls = ClsLwd;
      4'd8:                   cls = ClsSwd;
      4'd9:                   cls = ClsJmp;
      4'd10:                  cls = ClsJal;
      4'd15: begin
        if (func < 6'd8) begin
          cls = ClsAlu;
        end else begin
          case (func)
            6'd25:   cls = ClsJpr;
            6'd26:   cls = ClsJrl;
            6'd28:   cls = ClsWwd;
            6'd29:   cls = ClsHlt;
            default: cls = ClsNop;
          endcase
        end
      end
      default: cls = ClsNop;
    endcase
  end

  // ---------------------------------------------------------------------
  // Next state and Moore outputs (ir/mdr/IF-pc writes qualified by mem_ready)
  // ---------------------------------------------------------------------
  logic base_next_err;

  always_comb begin
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = 1'b0;
    ir_write    = 1'b0;
    mdr_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PcSeq;
    reg_write   = 1'b0;
    wb_reg_sel  = RegRt;
    wb_data_sel = DataAlu;
    alu_src_imm = 1'b0;
    out_valid   = 1'b0;
    is_halted   = 1'b0;

    unique case (state_q)
      StRst: state_d = StIf;

      StIf: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PcSeq;
          state_d  = StId;
        end
      end

      StId: begin
        case (cls)
          ClsJmp: begin
            pc_write = 1'b1;
            pc_src   = PcJmp;
            state_d  = StIf;
          end
          ClsJal:  state_d = StWb;
          ClsHlt:  state_d = StHalt;
          ClsNop:  state_d = StIf;
          default: state_d = StEx;
        endcase
      end

      StEx: begin
        case (cls)
          ClsAlu, ClsJrl: state_d = StWb;
          ClsImm: begin
            alu_src_imm = 1'b1;
            state_d     = StWb;
          end
          ClsLwd, ClsSwd: begin
            alu_src_imm = 1'b1;
            state_d     = StMem;
          end
          ClsBr: begin
            pc_write = bcond;
            pc_src   = PcBr;
            state_d  = StIf;
          end
          ClsJpr: begin
            pc_write = 1'b1;
            pc_src   = PcRegA;
            state_d  = StIf;
          end
          ClsWwd: begin
            out_valid = 1'b1;
            state_d   = StIf;
          end
          default: state_d = StIf;
        endcase
      end

      StMem: begin
        addr_sel    = 1'b1;
        alu_src_imm = 1'b1;
        mem_read    = (cls == ClsLwd);
        mem_write   = (cls == ClsSwd);
        if (mem_ready) begin
          if (cls == ClsLwd) begin
            mdr_write = 1'b1;
            state_d   = StWb;
          end else begin
            state_d = StIf;
          end
        end
      end

      StWb: begin
        reg_write = 1'b1;
        state_d   = StIf;
        case (cls)
          ClsAlu: wb_reg_sel = RegRd;
          ClsLwd: wb_data_sel = DataMdr;
          ClsJal: begin
            wb_reg_sel  = RegR2;
            wb_data_sel = DataPc;
            pc_write    = 1'b1;
            pc_src      = PcJmp;
          end
          ClsJrl: begin
            wb_reg_sel  = RegR2;
            wb_data_sel = DataPc;
            pc_write    = 1'b1;
            pc_src      = PcRegA;
          end
          default: begin
            wb_reg_sel  = RegRt;
            wb_data_sel = DataAlu;
          end
        endcase
      end

      StHalt: is_halted = 1'b1;

      StErr: state_d = StErr;

      default: state_d = StRst;
    endcase

    if (base_next_err) begin
      state_d = StErr;
    end
  end

  // An instruction retires when control leaves its last state for IF or HALT.
  assign retire = (state_q inside {StId, StEx, StMem, StWb}) &&
                  (state_d inside {StIf, StHalt});
  assign num_d  = retire ? num_q + CNT_W'(1) : num_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRst;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
    end
  end

  assign num_inst = num_q;

  // ---------------------------------------------------------------------
  // Optional memory wait timeout
  // ---------------------------------------------------------------------
`ifdef MCYCLE_SEQ_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  logic [WaitW-1:0] wait_q, wait_d;
  logic             waiting;

  assign waiting       = ((state_q == StIf) || (state_q == StMem)) && !mem_ready;
  assign base_next_err = waiting && (wait_q == WaitW'(TIMEOUT - 1));

  // Counter restarts whenever the state changes, i.e. on entry to IF/MEM.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign mem_err = (state_q == StErr);
`else
  logic unused_cfg;
  assign unused_cfg    = ^TIMEOUT;
  assign base_next_err = 1'b0;
  assign mem_err       = 1'b0;
`endif

endmodule

// File: tb/tb_mcycle_seq.sv
// tb_mcycle_seq: directed self-checking bench for mcycle_seq.
// Drives IR contents / bcond / mem_ready per cycle and compares the full
// control word and the retired-instruction count against hand-computed values.

module tb_mcycle_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] inst;
  logic        bcond;
  logic        mem_ready;
  logic        mem_read, mem_write, addr_sel, ir_write, mdr_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  wb_reg_sel, wb_data_sel;
  logic        alu_src_imm, out_valid, is_halted, mem_err;
  logic [15:0] num_inst;

  always #5 clk = ~clk;

  mcycle_seq #(
    .CNT_W   (16),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst        (inst),
    .bcond       (bcond),
    .mem_ready   (mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .addr_sel    (addr_sel),
    .ir_write    (ir_write),
    .mdr_write   (mdr_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .wb_reg_sel  (wb_reg_sel),
    .wb_data_sel (wb_data_sel),
    .alu_src_imm (alu_src_imm),
    .out_valid   (out_valid),
    .is_halted   (is_halted),
    .mem_err     (mem_err),
    .num_inst    (num_inst)
  );

  // Control word: one bit/field per output, MSB first.
  logic [16:0] ctl;
  assign ctl = {mem_read, mem_write, addr_sel, ir_write, mdr_write, pc_write, pc_src,
                reg_write, wb_reg_sel, wb_data_sel, alu_src_imm, out_valid, is_halted,
                mem_err};

  localparam logic [16:0] C_MRD  = 17'h10000;
  localparam logic [16:0] C_MWR  = 17'h08000;
  localparam logic [16:0] C_ASEL = 17'h04000;
  localparam logic [16:0] C_IRW  = 17'h02000;
  localparam logic [16:0] C_MDRW = 17'h01000;
  localparam logic [16:0] C_PCW  = 17'h00800;
  localparam logic [16:0] C_PCS1 = 17'h00200;
  localparam logic [16:0] C_PCS2 = 17'h00400;
  localparam logic [16:0] C_PCS3 = 17'h00600;
  localparam logic [16:0] C_RW   = 17'h00100;
  localparam logic [16:0] C_RD   = 17'h00040;
  localparam logic [16:0] C_R2   = 17'h00080;
  localparam logic [16:0] C_DMDR = 17'h00010;
  localparam logic [16:0] C_DPC  = 17'h00020;
  localparam logic [16:0] C_IMM  = 17'h00008;
  localparam logic [16:0] C_OUT  = 17'h00004;
  localparam logic [16:0] C_HLT  = 17'h00002;
  localparam logic [16:0] C_ERR  = 17'h00001;
  localparam logic [16:0] C_IF   = C_MRD | C_IRW | C_PCW;

  int unsigned chk_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, check the control word, advance past the edge.
  task automatic cyc(input string tag, input logic [15:0] i, input logic b, input logic r,
                     input logic [16:0] exp);
    inst      = i;
    bcond     = b;
    mem_ready = r;
    #1;
    check(tag, {15'b0, ctl}, {15'b0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic check_num(input string tag, input logic [15:0] exp);
    check(tag, {16'b0, num_inst}, {16'b0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    inst      = 16'h0000;
    bcond     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", {15'b0, ctl}, 32'd0);
    check_num("reset_num", 16'd0);
    reset = 1'b0;
    cyc("rst_state", 16'h0000, 1'b0, 1'b1, 17'h0);

    // ADI $1,5
    cyc("adi_if", 16'h4505, 1'b0, 1'b1, C_IF);
    cyc("adi_id", 16'h4505, 1'b0, 1'b1, 17'h0);
    cyc("adi_ex", 16'h4505, 1'b0, 1'b1, C_IMM);
    check_num("adi_num_pre", 16'd0);
    cyc("adi_wb", 16'h4505, 1'b0, 1'b1, C_RW);
    check_num("adi_num", 16'd1);

    // LWD with three MEM wait cycles
    cyc("lwd_if", 16'h7000, 1'b0, 1'b1, C_IF);
    cyc("lwd_id", 16'h7000, 1'b0, 1'b1, 17'h0);
    cyc("lwd_ex", 16'h7000, 1'b0, 1'b1, C_IMM);
    for (int k = 0; k < 3; k++) cyc("lwd_mem_wait", 16'h7000, 1'b0, 1'b0, C_MRD | C_ASEL | C_IMM);
    check_num("lwd_num_stall", 16'd1);
    cyc("lwd_mem_rdy", 16'h7000, 1'b0, 1'b1, C_MRD | C_ASEL | C_IMM | C_MDRW);
    cyc("lwd_wb", 16'h7000, 1'b0, 1'b1, C_RW | C_DMDR);
    check_num("lwd_num", 16'd2);

    // SWD with one IF wait cycle
    cyc("swd_if_wait", 16'h8000, 1'b0, 1'b0, C_MRD);
    cyc("swd_if", 16'h8000, 1'b0, 1'b1, C_IF);
    cyc("swd_id", 16'h8000, 1'b0, 1'b1, 17'h0);
    cyc("swd_ex", 16'h8000, 1'b0, 1'b1, C_IMM);
    cyc("swd_mem", 16'h8000, 1'b0, 1'b1, C_MWR | C_ASEL | C_IMM);
    check_num("swd_num", 16'd3);

    // BNE not taken, then taken; mem_ready low in ID/EX is ignored
    cyc("bne0_if", 16'h0000, 1'b0, 1'b1, C_IF);
    cyc("bne0_id", 16'h0000, 1'b0, 1'b0, 17'h0);
    cyc("bne0_ex", 16'h0000, 1'b0, 1'b0, C_PCS2);
    check_num("bne0_num", 16'd4);
    cyc("bne1_if", 16'h0000, 1'b1, 1'b1, C_IF);
    cyc("bne1_id", 16'h0000, 1'b1, 1'b1, 17'h0);
    cyc("bne1_ex", 16'h0000, 1'b1, 1'b1, C_PCW | C_PCS2);
    check_num("bne1_num", 16'd5);

    // JAL then WWD
    cyc("jal_if", 16'hA010, 1'b0, 1'b1, C_IF);
    cyc("jal_id", 16'hA010, 1'b0, 1'b1, 17'h0);
    cyc("jal_wb", 16'hA010, 1'b0, 1'b1, C_RW | C_R2 | C_DPC | C_PCW | C_PCS1);
    check_num("jal_num", 16'd6);
    cyc("wwd_if", 16'hF01C, 1'b0, 1'b1, C_IF);
    cyc("wwd_id", 16'hF01C, 1'b0, 1'b1, 17'h0);
    cyc("wwd_ex", 16'hF01C, 1'b0, 1'b1, C_OUT);
    check_num("wwd_num", 16'd7);

    // JMP, undefined opcode, undefined func
    cyc("jmp_if", 16'h9000, 1'b0, 1'b1, C_IF);
    cyc("jmp_id", 16'h9000, 1'b0, 1'b1, C_PCW | C_PCS1);
    check_num("jmp_num", 16'd8);
    cyc("nop_if", 16'hB000, 1'b0, 1'b1, C_IF);
    cyc("nop_id", 16'hB000, 1'b0, 1'b1, 17'h0);
    cyc("nopf_if", 16'hF008, 1'b0, 1'b1, C_IF);
    cyc("nopf_id", 16'hF008, 1'b0, 1'b1, 17'h0);
    check_num("nop_num", 16'd10);

    // R-ALU ADD, JPR, JRL
    cyc("add_if", 16'hF1C0, 1'b0, 1'b1, C_IF);
    cyc("add_id", 16'hF1C0, 1'b0, 1'b1, 17'h0);
    cyc("add_ex", 16'hF1C0, 1'b0, 1'b1, 17'h0);
    cyc("add_wb", 16'hF1C0, 1'b0, 1'b1, C_RW | C_RD);
    cyc("jpr_if", 16'hF019, 1'b0, 1'b1, C_IF);
    cyc("jpr_id", 16'hF019, 1'b0, 1'b1, 17'h0);
    cyc("jpr_ex", 16'hF019, 1'b0, 1'b1, C_PCW | C_PCS3);
    cyc("jrl_if", 16'hF01A, 1'b0, 1'b1, C_IF);
    cyc("jrl_id", 16'hF01A, 1'b0, 1'b1, 17'h0);
    cyc("jrl_ex", 16'hF01A, 1'b0, 1'b1, 17'h0);
    cyc("jrl_wb", 16'hF01A, 1'b0, 1'b1, C_RW | C_R2 | C_DPC | C_PCW | C_PCS3);
    check_num("jrl_num", 16'd13);

    // HLT: terminal, count frozen
    cyc("hlt_if", 16'hF01D, 1'b0, 1'b1, C_IF);
    cyc("hlt_id", 16'hF01D, 1'b0, 1'b1, 17'h0);
    check_num("hlt_num", 16'd14);
    for (int k = 0; k < 20; k++) cyc("hlt_hold", 16'hF01D, k[0], k[1], C_HLT);
    check_num("hlt_num_frozen", 16'd14);

    // Asynchronous reset pulse between clock edges
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ctl", {15'b0, ctl}, 32'd0);
    check_num("async_rst_num", 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("rst2_state", 16'h0000, 1'b0, 1'b1, 17'h0);

    // Abort an ADI in WB: must not retire
    cyc("abort_if", 16'h4505, 1'b0, 1'b1, C_IF);
    cyc("abort_id", 16'h4505, 1'b0, 1'b1, 17'h0);
    cyc("abort_ex", 16'h4505, 1'b0, 1'b1, C_IMM);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_num("abort_num", 16'd0);
    reset = 1'b0;
    cyc("rst3_state", 16'h9000, 1'b0, 1'b1, 17'h0);
    cyc("jmp2_if", 16'h9000, 1'b0, 1'b1, C_IF);
    cyc("jmp2_id", 16'h9000, 1'b0, 1'b1, C_PCW | C_PCS1);
    check_num("jmp2_num", 16'd1);

`ifdef MCYCLE_SEQ_TIMEOUT_EN
    // Timeout: four IF wait cycles, then sticky ERR
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("to_rst", 16'h0000, 1'b0, 1'b0, 17'h0);
    for (int k = 0; k < 4; k++) cyc("to_wait", 16'h0000, 1'b0, 1'b0, C_MRD);
    cyc("to_err", 16'h0000, 1'b0, 1'b1, C_ERR);
    cyc("to_sticky", 16'h0000, 1'b0, 1'b1, C_ERR);
`endif

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
